// File: rtl/wormhole_output_allocator.sv
// ---------------------------------------------------------------------------
// wormhole_output_allocator
//
// Per-output-port allocator for a wormhole-switched NoC router. One input
// port is granted exclusive ownership of this output from the head flit up
// to the tail flit. Between packets a work-conserving round-robin pointer
// picks the next owner: idle requesters are skipped within the same
// arbitration, so no cycle is spent on an empty slot.
//
// Ports
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset
//   req_i     [IN_N]        input i presents a flit routed to this output
//   last_i    [IN_N]        flit on input i is a tail flit (valid with req_i)
//   ready_i                 downstream link accepts a flit this cycle
//   grant_o   [IN_N]        registered one-hot (or zero) owner
//   sel_o     [$clog2(IN_N)] registered binary owner index, holds when idle
//   ack_o     [IN_N]        grant_o gated by ready_i; input pops on ack & req
//   valid_o                 owner currently presents a flit
//   busy_o                  registered, high while a packet holds the output
//   err_o                   sticky: a packet ran past MAX_PKT_LEN flits
// ---------------------------------------------------------------------------
module wormhole_output_allocator #(
    parameter int IN_N        = 5,
    parameter int MAX_PKT_LEN = 16,
    localparam int SEL_W      = (IN_N > 1) ? $clog2(IN_N) : 1,
    localparam int CNT_W      = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN + 1) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IN_N-1:0]  req_i,
    input  logic [IN_N-1:0]  last_i,
    input  logic             ready_i,
    output logic [IN_N-1:0]  grant_o,
    output logic [SEL_W-1:0] sel_o,
    output logic [IN_N-1:0]  ack_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Registered state (_p1) and its next-cycle value (_p0).
    state_e             state_p1, state_p0;
    logic [SEL_W-1:0]   ptr_p1,   ptr_p0;
    logic [CNT_W-1:0]   cnt_p1,   cnt_p0;
    logic [IN_N-1:0]    grant_p1, grant_p0;
    logic [SEL_W-1:0]   sel_p1,   sel_p0;
    logic               busy_p1,  busy_p0;
    logic               err_p1,   err_p0;

    logic               xfer;
    logic               owner_tail;
    logic               len_limit;
    logic [SEL_W:0]     pick;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;

    // Round-robin search: first requester at or after 'start', wrapping.
    // Returns {found, index}. Because the search walks every offset in one
    // pass, requesters that are idle simply cost nothing.
    function automatic logic [SEL_W:0] rr_pick(
        input logic [IN_N-1:0]  req,
        input logic [SEL_W-1:0] start
    );
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] cand;
        int               c;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < IN_N; off++) begin
            c = int'(start) + off;
            if (c >= IN_N) begin
                c = c - IN_N;
            end
            cand = SEL_W'(c);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // Index following 'i', modulo IN_N. Used to demote the releasing owner.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] i);
        if (i == SEL_W'(IN_N - 1)) begin
            return '0;
        end
        return i + SEL_W'(1);
    endfunction

    function automatic logic [IN_N-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [IN_N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Combinational handshake toward the inputs and the downstream link.
    // Only the registered grant feeds these; req_i never reaches grant_o
    // within a cycle.
    assign ack_o      = grant_p1 & {IN_N{ready_i}};
    assign valid_o    = |(grant_p1 & req_i);
    assign xfer       = valid_o & ready_i;
    // Tail flag is taken only from the owner; other inputs' last_i are masked.
    assign owner_tail = |(grant_p1 & last_i);
    assign len_limit  = (cnt_p1 == CNT_W'(MAX_PKT_LEN - 1));

    assign pick       = rr_pick(req_i, ptr_p1);
    assign pick_found = pick[SEL_W];
    assign pick_idx   = pick[SEL_W-1:0];

    always_comb begin
        state_p0 = state_p1;
        ptr_p0   = ptr_p1;
        cnt_p0   = cnt_p1;
        grant_p0 = grant_p1;
        sel_p0   = sel_p1;
        busy_p0  = busy_p1;
        err_p0   = err_p1;

        unique case (state_p1)
            IDLE: begin
                if (pick_found) begin
                    state_p0 = LOCKED;
                    grant_p0 = onehot(pick_idx);
                    sel_p0   = pick_idx;
                    busy_p0  = 1'b1;
                    cnt_p0   = '0;
                end else begin
                    grant_p0 = '0;
                end
            end
            LOCKED: begin
                // Bubbles (owner req low) and backpressure hold everything.
                if (xfer) begin
                    if (owner_tail || len_limit) begin
                        // Tail and overlong packets release the same way;
                        // only the overlong case flags an error.
                        state_p0 = IDLE;
                        grant_p0 = '0;
                        busy_p0  = 1'b0;
                        cnt_p0   = '0;
                        ptr_p0   = wrap_inc(sel_p1);
                        if (!owner_tail) begin
                            err_p0 = 1'b1;
                        end
                    end else begin
                        cnt_p0 = cnt_p1 + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_p0 = IDLE;
            end
        endcase
    end

    // ---- stage boundary: allocator state registers ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_p1 <= IDLE;
            ptr_p1   <= '0;
            cnt_p1   <= '0;
            grant_p1 <= '0;
            sel_p1   <= '0;
            busy_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            state_p1 <= state_p0;
            ptr_p1   <= ptr_p0;
            cnt_p1   <= cnt_p0;
            grant_p1 <= grant_p0;
            sel_p1   <= sel_p0;
            busy_p1  <= busy_p0;
            err_p1   <= err_p0;
        end
    end

    assign grant_o = grant_p1;
    assign sel_o   = sel_p1;
    assign busy_o  = busy_p1;
    assign err_o   = err_p1;

endmodule

// File: doc/wormhole_output_allocator.md
# wormhole_output_allocator

Per-output-port allocator for the NoC switch. It grants one input port exclusive ownership of its output port for the duration of a whole packet, from head flit to tail flit, which is wormhole switching. It re-arbitrates with a work-conserving round-robin pointer, so an idle requester never costs a cycle. It sits between the input buffers and the crossbar select of each switch output, and it drives the valid/ready handshake toward the downstream link.

## Interface
- IN_N, 5: number of input ports competing for this output.
- MAX_PKT_LEN, 16: maximum flits per packet. At this length the lock is force-released as a protocol error.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- req_i  input  IN_N  bit i high means input i presents a flit routed to this output.
- last_i  input  IN_N  bit i high means the flit presented by input i is a tail flit. Only meaningful when req_i[i] is high.
- ready_i  input  1  downstream link can accept a flit this cycle.
- grant_o  output  IN_N  registered, one-hot or zero; current owner of the output.
- sel_o  output  $clog2(IN_N)  registered binary index of the owner; holds its last value when idle.
- ack_o  output  IN_N  combinational, equal to grant_o & {IN_N{ready_i}}. Input i pops its flit when ack_o[i] & req_i[i].
- valid_o  output  1  combinational, equal to |(grant_o & req_i). Valid flit toward downstream.
- busy_o  output  1  registered; high while in LOCKED.
- err_o  output  1  registered, sticky until reset; a packet exceeded MAX_PKT_LEN.

## Operation
- State: state (IDLE/LOCKED), ptr (round-robin pointer, index), cnt (flits in current packet, width $clog2(MAX_PKT_LEN+1)), plus the registered outputs.
- Transfer condition: xfer = valid_o & ready_i.
- IDLE:
  - If req_i is nonzero, choose the first i with req_i[i] high, searching ptr, ptr+1, … and wrapping modulo IN_N.
  - Next cycle: grant_o = onehot(i), sel_o = i, busy_o = 1, cnt = 0, state = LOCKED.
  - If req_i is zero, stay in IDLE with grant_o = 0.
- LOCKED, owner k:
  - No xfer: hold all state. This covers owner req low (a bubble) and ready_i low (backpressure).
  - Requests from other inputs are ignored while locked.
  - xfer with last_i[k] high: release. Next cycle grant_o = 0, busy_o = 0, state = IDLE, ptr = (k+1) mod IN_N, cnt = 0.
  - xfer with last_i[k] low and cnt < MAX_PKT_LEN-1: cnt increments.
  - xfer with last_i[k] low and cnt == MAX_PKT_LEN-1: forced release, identical to a tail release, and err_o is set.
- A single-flit packet (head and tail together, last_i high on the first xfer) releases after one transfer.
- ptr changes only on release. An arbitration with no transfer does not move it.
- Fairness: after owner k releases, input k has the lowest priority at the next arbitration.
- last_i and req_i of non-owner inputs never affect LOCKED state.

## Timing
- Reset values: grant_o = 0, sel_o = 0, busy_o = 0, err_o = 0, ptr = 0, cnt = 0, state = IDLE. ack_o and valid_o are therefore 0 during reset.
- Arbitration latency: a request sampled in IDLE at edge N gives grant_o at N+1, and the first xfer is possible in the cycle after edge N+1.
- A tail xfer in cycle M gives grant_o = 0 in cycle M+1 (one mandatory idle cycle). The next grant is earliest in cycle M+2.
- Sustained throughput while locked with req and ready held high: one flit per cycle.
- Reset asserted mid-packet: all outputs return to their reset values immediately, asynchronously. The partial packet is abandoned and no state is retained.
- ack_o and valid_o are purely combinational from the registered grant_o and the current-cycle inputs. There is no path from req_i to grant_o within a cycle.

## Test plan
- Single requester: req_i = 5'b00100 with a 3-flit packet (tail on the 3rd) and ready_i = 1. Required: grant_o = 00100 one cycle later, three xfers in consecutive cycles, grant_o = 0 the following cycle, ptr = 3.
- Round-robin fairness: all 5 inputs request continuously with 1-flit packets and ready_i = 1. Required grant order 0,1,2,3,4,0, with a grant every second cycle.
- Backpressure and bubbles: owner 2 sends a 4-flit packet. ready_i is low for 3 cycles mid-packet and req_i[2] drops for 2 cycles. Required: grant_o holds 00100 throughout, exactly 4 acks, release only on the tail, other requesters are never granted meanwhile.
- Work-conserving skip: ptr = 1 and only req_i[4] is high. Required: grant_o = 10000 one cycle after sampling and sel_o = 4, with no wasted arbitration cycles.
- Overlong packet: MAX_PKT_LEN = 16 and owner 0 sends 20 flits with no tail. Required: forced release after the 16th xfer, err_o = 1 and sticky, ptr = 1.
- Reset mid-packet: assert rst_ni low during the 2nd flit. Required: grant_o, busy_o and err_o are 0 immediately. After deassertion, the lowest requesting index from 0 upward wins.
